// File: rtl/signed_bcd_converter.sv
// Signed binary to packed-BCD converter.
// Registers the sign and magnitude of a two's-complement input and runs a
// serial double-dabble conversion, one bit per clock. Results are held
// stable from one done pulse to the next.
module signed_bcd_converter #(
  parameter int bits   = 8,
  parameter int digits = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [bits:0]    value,
  input  logic                    start,
  output logic [4*digits-1:0]     bcd,
  output logic                    negative,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
);

  localparam int CntW = $clog2(bits + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [bits:0]       mag_work;
  logic [4*digits-1:0] bcd_work;
  logic [CntW-1:0]     cnt;
  logic                neg_int;
  logic                ovf_int;

  logic [bits:0]       value_u;
  logic [bits:0]       mag_in;
  logic [4*digits-1:0] bcd_adj;
  logic [4*digits-1:0] bcd_shifted;
  logic                ovf_next;
  logic                last_shift;

  // Magnitude is one bit wider than the data bits, so -2^bits maps to 2^bits.
  always_comb begin
    value_u = value;
    if (value_u[bits]) begin
      mag_in = ~value_u + {{bits{1'b0}}, 1'b1};
    end else begin
      mag_in = value_u;
    end
  end

  // Double-dabble step: add 3 to digits >= 5, then shift in the next magnitude bit.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < digits; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4];
      end
    end
    bcd_shifted = {bcd_adj[4*digits-2:0], mag_work[bits]};
    // Any 1 leaving the top digit means the magnitude does not fit.
    ovf_next    = ovf_int | bcd_adj[4*digits-1];
    last_shift  = (cnt == CntW'(1));
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag_work <= '0;
      bcd_work <= '0;
      cnt      <= '0;
      neg_int  <= 1'b0;
      ovf_int  <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            neg_int  <= value_u[bits];
            mag_work <= mag_in;
            bcd_work <= '0;
            ovf_int  <= 1'b0;
            cnt      <= CntW'(bits + 1);
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_shifted;
          mag_work <= {mag_work[bits-1:0], 1'b0};
          ovf_int  <= ovf_next;
          cnt      <= cnt - CntW'(1);
          if (last_shift) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= bcd_shifted;
            negative <= neg_int;
            overflow <= ovf_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed bench for signed_bcd_converter: a 3-digit and a 2-digit instance
// share clock, reset and stimulus; expected results are hand-computed.
module tb_signed_bcd_converter;

  logic              clk;
  logic              rst;
  logic signed [8:0] value;
  logic              start;

  logic [11:0] bcd3;
  logic        neg3, ovf3, busy3, done3;
  logic [7:0]  bcd2;
  logic        neg2, ovf2, busy2, done2;

  int assertions;
  int failures;

  signed_bcd_converter #(.bits(8), .digits(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .start    (start),
    .bcd      (bcd3),
    .negative (neg3),
    .overflow (ovf3),
    .busy     (busy3),
    .done     (done3)
  );

  signed_bcd_converter #(.bits(8), .digits(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .start    (start),
    .bcd      (bcd2),
    .negative (neg2),
    .overflow (ovf2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start pulse; returns at the falling edge after the accepting edge.
  task automatic start_conv(input logic signed [8:0] v);
    value = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count rising edges until done is seen; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done3) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    assertions++;
    if (bcd3 !== 12'h000) begin failures++; $display("FAIL reset_bcd got %h want 000", bcd3); end
    assertions++;
    if ({neg3, ovf3, busy3, done3} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got %b want 0000", {neg3, ovf3, busy3, done3});
    end
    assertions++;
    if ({bcd2, neg2, ovf2, busy2, done2} !== 12'h000) begin
      failures++; $display("FAIL reset_dut2 got %h want 000", {bcd2, neg2, ovf2, busy2, done2});
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int n;
    start_conv(9'sd123);
    assertions++;
    if (busy3 !== 1'b1) begin failures++; $display("FAIL normal_busy got %b want 1", busy3); end
    wait_done(n);
    assertions++;
    if (n !== 9) begin failures++; $display("FAIL normal_latency got %0d want 9", n); end
    assertions++;
    if (bcd3 !== 12'h123) begin failures++; $display("FAIL normal_bcd got %h want 123", bcd3); end
    assertions++;
    if ({neg3, ovf3, busy3} !== 3'b000) begin
      failures++; $display("FAIL normal_flags got %b want 000", {neg3, ovf3, busy3});
    end
    @(negedge clk);
    assertions++;
    if (done3 !== 1'b0) begin failures++; $display("FAIL normal_done_width got %b want 0", done3); end
  endtask

  task automatic test_negative();
    int n;
    start_conv(-9'sd256);
    wait_done(n);
    assertions++;
    if ({bcd3, neg3, ovf3} !== {12'h256, 2'b10}) begin
      failures++; $display("FAIL neg256 got %h/%b/%b want 256/1/0", bcd3, neg3, ovf3);
    end
    @(negedge clk);
    start_conv(-9'sd1);
    wait_done(n);
    assertions++;
    if ({bcd3, neg3} !== {12'h001, 1'b1}) begin
      failures++; $display("FAIL neg1 got %h/%b want 001/1", bcd3, neg3);
    end
  endtask

  task automatic test_zero_ignored();
    int pulses;
    int first;
    logic [11:0] res;
    logic        res_neg;
    pulses = 0;
    first  = -1;
    res     = 12'hfff;
    res_neg = 1'bx;
    start_conv(9'sd0);
    @(negedge clk);
    @(negedge clk);
    start_conv(9'sd5);
    for (int i = 4; i <= 25; i++) begin
      @(negedge clk);
      if (done3) begin
        pulses++;
        if (first < 0) begin first = i; res = bcd3; res_neg = neg3; end
      end
    end
    assertions++;
    if (pulses !== 1) begin failures++; $display("FAIL zero_pulses got %0d want 1", pulses); end
    assertions++;
    if (first !== 9) begin failures++; $display("FAIL zero_latency got %0d want 9", first); end
    assertions++;
    if ({res, res_neg} !== {12'h000, 1'b0}) begin
      failures++; $display("FAIL zero_result got %h/%b want 000/0", res, res_neg);
    end
  endtask

  task automatic test_overflow();
    int n;
    start_conv(9'sd200);
    wait_done(n);
    assertions++;
    if ({done2, ovf2} !== 2'b11) begin
      failures++; $display("FAIL ovf200 got done=%b ovf=%b want 1/1", done2, ovf2);
    end
    assertions++;
    if ({bcd3, ovf3} !== {12'h200, 1'b0}) begin
      failures++; $display("FAIL ovf200_wide got %h/%b want 200/0", bcd3, ovf3);
    end
    @(negedge clk);
    start_conv(9'sd99);
    wait_done(n);
    assertions++;
    if ({bcd2, ovf2, done2} !== {8'h99, 2'b01}) begin
      failures++; $display("FAIL ovf99 got %h/%b/%b want 99/0/1", bcd2, ovf2, done2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int n;
    pulses = 0;
    start_conv(9'sd200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    assertions++;
    if ({bcd3, neg3, ovf3, busy3, done3} !== 16'h0000) begin
      failures++; $display("FAIL midrst_outputs got %h want 0000", {bcd3, neg3, ovf3, busy3, done3});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done3) pulses++;
    end
    assertions++;
    if (pulses !== 0) begin failures++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
    start_conv(9'sd42);
    wait_done(n);
    assertions++;
    if ({bcd3, neg3, ovf3} !== {12'h042, 2'b00}) begin
      failures++; $display("FAIL midrst_next got %h/%b/%b want 042/0/0", bcd3, neg3, ovf3);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    logic held;
    held = 1'b1;
    start_conv(9'sd123);
    wait_done(n);
    // Still in the done cycle: request the next conversion immediately.
    start_conv(-9'sd45);
    assertions++;
    if ({busy3, done3, bcd3} !== {2'b10, 12'h123}) begin
      failures++; $display("FAIL b2b_accept got busy=%b done=%b bcd=%h want 1/0/123", busy3, done3, bcd3);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bcd3 !== 12'h123 || neg3 !== 1'b0 || done3 !== 1'b0) held = 1'b0;
    end
    assertions++;
    if (held !== 1'b1) begin failures++; $display("FAIL b2b_hold got %b want 1", held); end
    @(negedge clk);
    assertions++;
    if ({done3, bcd3, neg3} !== {1'b1, 12'h045, 1'b1}) begin
      failures++; $display("FAIL b2b_result got %b/%h/%b want 1/045/1", done3, bcd3, neg3);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    @(negedge clk);
    test_reset();
    test_normal();
    test_negative();
    @(negedge clk);
    test_zero_ignored();
    test_overflow();
    @(negedge clk);
    test_reset_mid();
    @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
